// File: rtl/ipv4_local_lut_arbiter.sv
// Round-robin arbiter sharing the IPv4 local-address LUT lookup port between
// NUM_REQ requesters; a tag FIFO steers in-order LUT results back to their owner.
module ipv4_local_lut_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int REQ_BITS        = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  input  logic [32*NUM_REQ-1:0]   i_req_daddr,
  output logic [NUM_REQ-1:0]      o_req_grant,
  output logic [31:0]             o_lut_daddr,
  output logic                    o_lut_daddr_valid,
  input  logic                    i_lut_is_local,
  input  logic                    i_lut_is_local_valid,
  output logic                    o_lut_rd,
  output logic [NUM_REQ-1:0]      o_rsp_valid,
  output logic                    o_rsp_is_local,
  input  logic [NUM_REQ-1:0]      i_rsp_ack,
  output logic                    o_err
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic {RSP_IDLE, RSP_HOLD} rsp_state_e;

  rsp_state_e            state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [REQ_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [REQ_BITS-1:0]   tag_mem_q [MAX_OUTSTANDING];
  logic [REQ_BITS-1:0]   rsp_tag_q, rsp_tag_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic                  rsp_local_q, rsp_local_d;
  logic                  err_q, err_d;
  logic [31:0]           lut_daddr_q, lut_daddr_d;
  logic                  lut_daddr_valid_q, lut_daddr_valid_d;

  logic                  can_issue, found, issue, lut_rd, pop;
  logic [REQ_BITS-1:0]   cand, gnt_idx;
  logic [NUM_REQ-1:0]    grant;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // The cap is checked against the pre-pop count, so a full table stalls
  // issue even in a cycle where a result is being returned.
  assign can_issue = (count_q < CNT_W'(MAX_OUTSTANDING)) && (|i_req_valid);

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = REQ_BITS'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (can_issue && !found && i_req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    if (found) grant[gnt_idx] = 1'b1;
  end

  assign issue = found;

  always_comb begin
    lut_daddr_d       = lut_daddr_q;
    lut_daddr_valid_d = issue;
    rr_ptr_d          = rr_ptr_q;
    wr_ptr_d          = wr_ptr_q;
    if (issue) begin
      lut_daddr_d = i_req_daddr[32*int'(gnt_idx) +: 32];
      rr_ptr_d    = (gnt_idx == REQ_BITS'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      wr_ptr_d    = ptr_inc(wr_ptr_q);
    end
  end

  always_comb begin
    lut_rd      = (state_q == RSP_IDLE) && i_lut_is_local_valid;
    pop         = lut_rd && (count_q != '0);
    state_d     = state_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_valid_d = rsp_valid_q;
    rsp_local_d = rsp_local_q;
    rd_ptr_d    = rd_ptr_q;
    // A result with nothing outstanding is stray: drain it and flag it.
    err_d       = err_q | (lut_rd && (count_q == '0));
    case (state_q)
      RSP_IDLE: if (pop) begin
        rsp_tag_d              = tag_mem_q[rd_ptr_q];
        rsp_valid_d            = '0;
        rsp_valid_d[rsp_tag_d] = 1'b1;
        rsp_local_d            = i_lut_is_local;
        rd_ptr_d               = ptr_inc(rd_ptr_q);
        state_d                = RSP_HOLD;
      end
      RSP_HOLD: if (i_rsp_ack[rsp_tag_q]) begin
        rsp_valid_d = '0;
        state_d     = RSP_IDLE;
      end
      default: state_d = RSP_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({issue, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= RSP_IDLE;
      count_q           <= '0;
      rr_ptr_q          <= '0;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      rsp_tag_q         <= '0;
      rsp_valid_q       <= '0;
      rsp_local_q       <= 1'b0;
      err_q             <= 1'b0;
      lut_daddr_q       <= '0;
      lut_daddr_valid_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      count_q           <= count_d;
      rr_ptr_q          <= rr_ptr_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      rsp_tag_q         <= rsp_tag_d;
      rsp_valid_q       <= rsp_valid_d;
      rsp_local_q       <= rsp_local_d;
      err_q             <= err_d;
      lut_daddr_q       <= lut_daddr_d;
      lut_daddr_valid_q <= lut_daddr_valid_d;
    end
  end

  // Tag storage needs no reset: occupancy is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (issue) tag_mem_q[wr_ptr_q] <= gnt_idx;
  end

  assign o_req_grant       = grant;
  assign o_lut_daddr       = lut_daddr_q;
  assign o_lut_daddr_valid = lut_daddr_valid_q;
  assign o_lut_rd          = lut_rd;
  assign o_rsp_valid       = rsp_valid_q;
  assign o_rsp_is_local    = rsp_local_q;
  assign o_err             = err_q;

endmodule

// File: tb/tb_ipv4_local_lut_arbiter.sv
// Bench for ipv4_local_lut_arbiter: directed vector table, corner sequences and
// random traffic checked against a queue-based reference model with a LUT model.
module tb_ipv4_local_lut_arbiter;
  localparam int N    = 4;
  localparam int MAXO = 4;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [N-1:0] req_valid;
  logic [127:0] req_daddr;
  logic         lut_v, lut_l;
  logic [N-1:0] ack;

  logic [N-1:0] o_grant, o_rsp;
  logic [31:0]  o_daddr;
  logic         o_dv, o_rd, o_loc, o_err;

  ipv4_local_lut_arbiter #(.NUM_REQ(N), .REQ_BITS(2), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(rst),
    .i_req_valid(req_valid), .i_req_daddr(req_daddr), .o_req_grant(o_grant),
    .o_lut_daddr(o_daddr), .o_lut_daddr_valid(o_dv),
    .i_lut_is_local(lut_l), .i_lut_is_local_valid(lut_v), .o_lut_rd(o_rd),
    .o_rsp_valid(o_rsp), .o_rsp_is_local(o_loc), .i_rsp_ack(ack), .o_err(o_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  int           m_rr;
  int           m_tagq[$];
  logic [N-1:0] m_rsp_valid;
  int           m_rsp_tag;
  logic         m_is_local, m_err, m_dv;
  logic [31:0]  m_daddr;

  // LUT environment: result FIFO filled from issued lookups
  bit   lut_env;
  logic lutq[$];

  // outputs sampled at the last tick's negedge
  logic [N-1:0] s_grant, s_rsp;
  logic         s_rd, s_loc, s_err, s_dv;
  logic [31:0]  s_da;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic lut_is_local(input logic [31:0] a);
    return (a[31:24] == 8'd10) && a[0];
  endfunction

  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_tagq.size() < MAXO)
      for (int i = 0; i < N; i++) begin
        int idx;
        idx = (m_rr + i) % N;
        if (g == '0 && req_valid[idx]) g[idx] = 1'b1;
      end
    return g;
  endfunction

  task automatic tick();
    logic [N-1:0] eg;
    logic         erd;
    int           k;
    @(negedge clk);
    s_grant = o_grant; s_rsp = o_rsp; s_rd = o_rd; s_loc = o_loc;
    s_err = o_err; s_dv = o_dv; s_da = o_daddr;
    eg  = model_grant();
    erd = (m_rsp_valid == '0) && lut_v;
    if (!rst) begin
      chk("grant", 32'(s_grant), 32'(eg));
      chk("lut_rd", 32'(s_rd), 32'(erd));
      chk("rsp_valid", 32'(s_rsp), 32'(m_rsp_valid));
      if (m_rsp_valid != '0) chk("rsp_is_local", 32'(s_loc), 32'(m_is_local));
      chk("err", 32'(s_err), 32'(m_err));
      chk("daddr_valid", 32'(s_dv), 32'(m_dv));
      if (m_dv) chk("daddr", s_da, m_daddr);
    end
    if (rst) begin
      m_rr = 0; m_tagq.delete(); m_rsp_valid = '0; m_rsp_tag = 0;
      m_is_local = 1'b0; m_err = 1'b0; m_dv = 1'b0; m_daddr = '0;
    end else begin
      if (erd) begin
        if (m_tagq.size() > 0) begin
          m_rsp_tag = m_tagq.pop_front();
          m_rsp_valid = '0;
          m_rsp_valid[m_rsp_tag] = 1'b1;
          m_is_local = lut_l;
        end else m_err = 1'b1;
      end else if (m_rsp_valid != '0 && ack[m_rsp_tag]) m_rsp_valid = '0;
      m_dv = 1'b0;
      if (eg != '0) begin
        k = 0;
        for (int i = 0; i < N; i++) if (eg[i]) k = i;
        m_daddr = req_daddr[32*k +: 32];
        m_dv = 1'b1;
        m_tagq.push_back(k);
        m_rr = (k + 1) % N;
      end
    end
    @(posedge clk);
    #1;
    if (rst) lutq.delete();
    else if (lut_env) begin
      if (s_rd && lutq.size() > 0) void'(lutq.pop_front());
      if (s_dv) lutq.push_back(lut_is_local(s_da));
      lut_v = (lutq.size() > 0);
      lut_l = (lutq.size() > 0) ? lutq[0] : 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; ack = '0; lut_v = 1'b0; lut_l = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  typedef struct {
    logic [N-1:0] req; logic lv; logic ll; logic [N-1:0] ack;
    logic [N-1:0] g; logic rd; logic [N-1:0] rsp; logic loc; logic dv; logic [31:0] da;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int got_tag[$];
    logic got_loc[$];
    int exp_tag[3];
    logic exp_loc[3];
    bit seen;

    // addresses: req0 10.0.0.16, req1 10.0.0.2, req2 10.0.0.1, req3 10.0.0.3
    tbl[0]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{4'b1011, 1'b0, 1'b0, 4'b0000, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b1, 32'h0A000001};
    tbl[3]  = '{4'b1011, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 32'h0A000003};
    tbl[4]  = '{4'b1010, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b1, 32'h0A000010};
    tbl[5]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 32'h0A000002};
    tbl[6]  = '{4'b1111, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0};
    tbl[7]  = '{4'b1111, 1'b1, 1'b0, 4'b1011, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0, 32'h0};
    tbl[8]  = '{4'b1111, 1'b1, 1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b1, 32'h0A000001};
    tbl[9]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0};
    tbl[10] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b0, 32'h0};
    tbl[11] = '{4'b0000, 1'b0, 1'b0, 4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b0, 32'h0};
    tbl[12] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0};

    lut_env = 1'b0;
    req_daddr = {32'h0A000003, 32'h0A000001, 32'h0A000002, 32'h0A000010};
    do_reset();

    // reset values
    tick();
    chk("rst_grant", 32'(s_grant), 32'h0);
    chk("rst_daddr", s_da, 32'h0);
    chk("rst_dv", 32'(s_dv), 32'h0);
    chk("rst_rd", 32'(s_rd), 32'h0);
    chk("rst_rsp", 32'(s_rsp), 32'h0);
    chk("rst_loc", 32'(s_loc), 32'h0);
    chk("rst_err", 32'(s_err), 32'h0);

    // directed vector table
    do_reset();
    foreach (tbl[i]) begin
      req_valid = tbl[i].req; lut_v = tbl[i].lv; lut_l = tbl[i].ll; ack = tbl[i].ack;
      tick();
      chk($sformatf("tbl%0d_grant", i), 32'(s_grant), 32'(tbl[i].g));
      chk($sformatf("tbl%0d_rd", i), 32'(s_rd), 32'(tbl[i].rd));
      chk($sformatf("tbl%0d_rsp", i), 32'(s_rsp), 32'(tbl[i].rsp));
      if (tbl[i].rsp != '0) chk($sformatf("tbl%0d_loc", i), 32'(s_loc), 32'(tbl[i].loc));
      chk($sformatf("tbl%0d_dv", i), 32'(s_dv), 32'(tbl[i].dv));
      if (tbl[i].dv) chk($sformatf("tbl%0d_daddr", i), s_da, tbl[i].da);
    end

    // stray result: error flag, one-cycle drain, sticky until reset
    do_reset();
    lut_v = 1'b1; tick();
    chk("err_rd_pulse", 32'(s_rd), 32'h1);
    lut_v = 1'b0; tick();
    chk("err_rd_low", 32'(s_rd), 32'h0);
    chk("err_set", 32'(s_err), 32'h1);
    repeat (5) tick();
    chk("err_sticky", 32'(s_err), 32'h1);
    do_reset(); tick();
    chk("err_cleared", 32'(s_err), 32'h0);

    // ordering: 3 (local), 1 (non-local), 3 (local)
    lut_env = 1'b1;
    do_reset();
    req_daddr = {32'h0A000001, 32'h0, 32'h0A000002, 32'h0};
    req_valid = 4'b1000; tick();
    req_valid = 4'b0010; tick();
    req_valid = 4'b1000; tick();
    req_valid = 4'b0000;
    for (int c = 0; c < 40 && got_tag.size() < 3; c++) begin
      tick();
      if (s_rsp != '0 && ack == '0) begin
        got_tag.push_back(onehot_idx(s_rsp));
        got_loc.push_back(s_loc);
        ack = s_rsp;
      end else ack = '0;
    end
    ack = '0;
    exp_tag = '{3, 1, 3};
    exp_loc = '{1'b1, 1'b0, 1'b1};
    chk("order_count", 32'(got_tag.size()), 32'd3);
    for (int i = 0; i < 3 && i < got_tag.size(); i++) begin
      chk($sformatf("order%0d_tag", i), 32'(got_tag[i]), 32'(exp_tag[i]));
      chk($sformatf("order%0d_loc", i), 32'(got_loc[i]), 32'(exp_loc[i]));
    end

    // delayed ack with a second result waiting in the LUT
    do_reset();
    req_daddr = {32'h0A000002, 32'h0, 32'h0A000001, 32'h0};
    req_valid = 4'b0010; tick();
    req_valid = 4'b1000; tick();
    req_valid = 4'b0000;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      seen = (s_rsp == 4'b0010);
    end
    chk("dack_rsp_seen", 32'(seen), 32'h1);
    ack = 4'b1101;
    repeat (10) begin
      tick();
      chk("dack_rsp_hold", 32'(s_rsp), 32'h2);
      chk("dack_loc_hold", 32'(s_loc), 32'h1);
      chk("dack_rd_low", 32'(s_rd), 32'h0);
    end
    ack = 4'b0010; tick();
    ack = 4'b0000; tick();
    chk("dack_rsp_clear", 32'(s_rsp), 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      seen = (s_rsp == 4'b1000);
    end
    chk("dack_second_rsp", 32'(seen), 32'h1);
    ack = 4'b1000; tick(); ack = 4'b0000;

    // reset with 3 outstanding and a response held
    lut_env = 1'b0;
    do_reset();
    req_daddr = {32'h0A000003, 32'h0A000001, 32'h0A000002, 32'h0A000010};
    req_valid = 4'b1111;
    repeat (4) tick();
    req_valid = 4'b0000; lut_v = 1'b1; lut_l = 1'b1; tick();
    lut_v = 1'b0; tick();
    chk("mid_hold", 32'(s_rsp), 32'h1);
    rst = 1'b1; tick(); rst = 1'b0;
    tick();
    chk("mid_grant", 32'(s_grant), 32'h0);
    chk("mid_rsp", 32'(s_rsp), 32'h0);
    chk("mid_dv", 32'(s_dv), 32'h0);
    chk("mid_daddr", s_da, 32'h0);
    chk("mid_rd", 32'(s_rd), 32'h0);
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("mid_seq%0d", i), 32'(s_grant), (i < 4) ? (32'h1 << i) : 32'h0);
    end

    // random traffic against the model
    lut_env = 1'b1;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int k = 0; k < N; k++) begin
        if (s_grant[k] || !req_valid[k]) begin
          req_valid[k] = ($urandom_range(0, 2) != 0);
          case ($urandom_range(0, 3))
            0: req_daddr[32*k +: 32] = 32'h0A000001;
            1: req_daddr[32*k +: 32] = 32'h0A000002;
            2: req_daddr[32*k +: 32] = 32'h0A0000FF;
            default: req_daddr[32*k +: 32] = $urandom;
          endcase
        end
      end
      ack = 4'($urandom_range(0, 15));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
